systolic_activation_skewer: RTL and testbench
=============================================

Name: systolic_activation_skewer

Overview:
- Upstream feeder for the systolic array. Accepts one activation vector per beat over a valid/ready stream and applies the diagonal skew the array needs: row r is delayed r extra cycles.
- Drives the array's activations_in port directly.
- After the last beat of a frame, injects zero vectors until the array pipeline has drained, then pulses done_out.

Parameters:
- SYSTOLIC_ARRAY_ROWS, 8, number of array rows (activation lanes).
- SYSTOLIC_ARRAY_COLS, 8, number of array columns; used only to size the drain.
- FIXED_POINT_WIDTH, 16, bits per activation element.
- BEAT_COUNT_WIDTH, 16, width of the per-frame accepted-beat counter.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- act_valid_in  input  1  upstream beat valid.
- act_last_in  input  1  marks the final beat of a frame; qualified by accept.
- act_in  input  [ROWS-1:0][FIXED_POINT_WIDTH-1:0]  unskewed activation vector, lane r to row r.
- act_ready_out  output  1  skewer can accept a beat.
- activations_out  output  [ROWS-1:0][FIXED_POINT_WIDTH-1:0]  skewed vector to the array's activations_in.
- row_valid_out  output  [ROWS-1:0]  bit r high when activations_out[r] carries real (non-bubble, non-drain) data.
- busy_out  output  1  high in STREAM or DRAIN.
- done_out  output  1  one-cycle pulse in the final drain cycle.
- beat_count_out  output  BEAT_COUNT_WIDTH  beats accepted in the current/most recent frame.

Behaviour:
- Accept = act_valid_in & act_ready_out.
- act_ready_out = !rst_in & (state != DRAIN); combinational from state.
- Reset (synchronous): state=IDLE; all skew registers, activations_out, row_valid_out, beat_count_out = 0; busy_out=0; done_out=0.
- Skew datapath: row r is a shift chain of depth r+1 of {data, valid}.
  - Every cycle, stage 0 of each row loads act_in[r] with valid=1 on accept; otherwise it loads 0 with valid=0, covering bubbles, IDLE and DRAIN.
  - activations_out[r] / row_valid_out[r] are the last stage of row r.
  - Beat accepted in cycle k appears on row r in cycle k+1+r.
  - Invalid slots always carry data 0, never stale values.
- State IDLE: busy_out=0.
  - Accept with last=0 goes to STREAM; beat_count_out set to 1.
  - Accept with last=1 goes to DRAIN; beat_count_out set to 1.
- State STREAM: busy_out=1.
  - Each accept increments beat_count_out; the counter saturates at all-ones and does not wrap.
  - Accept with last=1 goes to DRAIN.
  - valid low is a bubble: a zero slot is inserted and the state holds.
- State DRAIN: busy_out=1; act_ready_out=0.
  - Counter runs D = ROWS+COLS-1 cycles (15 at defaults); zeros are injected.
  - Last beat accepted in cycle k: DRAIN occupies cycles k+1..k+D.
  - done_out=1 in cycle k+D only; state is IDLE in cycle k+D+1.
  - Because D >= ROWS, all real data has left the skew chains before done_out.
- beat_count_out holds its value through IDLE until the next frame's first accept reloads it to 1.
- act_last_in without act_valid_in is ignored.
- act_in changing while not accepted has no effect.
- Reset mid-frame (STREAM or DRAIN): the frame is aborted, skew chains are cleared, no done_out pulse, and the block is ready (IDLE) in the first cycle after rst_in deasserts.
- Back-to-back frames: act_ready_out returns high in cycle k+D+1, so a new frame's first beat can be accepted in that cycle. Minimum frame gap is D cycles.

Test Plan (defaults: ROWS=8, COLS=8, W=16, D=15):
- Reset: hold rst_in 3 cycles with act_valid_in=1 -> act_ready_out=0, all outputs 0, beat_count_out=0, no state change.
- Single-beat frame: accept act_in lane r = 0x0100+r with last=1 in cycle k ->
  - activations_out[r]=0x0100+r and row_valid_out[r]=1 only in cycle k+1+r;
  - act_ready_out=0 in cycles k+1..k+15;
  - done_out=1 in cycle k+15; beat_count_out=1.
- Streaming 4 beats, no gaps, values 0x0001..0x0004 in every lane, last on beat 4 ->
  - row 7 shows 1,2,3,4 in consecutive cycles starting 8 cycles after beat 1;
  - row 0 shows them starting 1 cycle after beat 1;
  - beat_count_out=4; done_out 15 cycles after beat 4.
- Bubble: beats A, gap of 2 cycles (valid low), B with last -> each row shows A, 0, 0, B with row_valid_out 1,0,0,1; state stays STREAM during the gap.
- Reset mid-DRAIN: assert rst_in 5 cycles after the last beat -> no done_out, skew chains zero next cycle, act_ready_out=1 the cycle after rst_in drops.
- Back-to-back frames: second frame's first beat presented continuously -> accepted exactly in cycle k+16; beat_count_out reloads to 1; no overlap of row_valid_out between frames.

Source files
------------

// File: rtl/systolic_activation_skewer.sv
// Feeds the systolic array's activations_in: applies the diagonal row skew to each accepted beat,
// then injects zero vectors after a frame's last beat until the array has drained, and pulses done_out.
module systolic_activation_skewer #(
    parameter int SYSTOLIC_ARRAY_ROWS = 8,
    parameter int SYSTOLIC_ARRAY_COLS = 8,
    parameter int FIXED_POINT_WIDTH   = 16,
    parameter int BEAT_COUNT_WIDTH    = 16
) (
    input  logic                                                   clk_in,
    input  logic                                                   rst_in,
    input  logic                                                   act_valid_in,
    input  logic                                                   act_last_in,
    input  logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0] act_in,
    output logic                                                   act_ready_out,
    output logic [SYSTOLIC_ARRAY_ROWS-1:0][FIXED_POINT_WIDTH-1:0] activations_out,
    output logic [SYSTOLIC_ARRAY_ROWS-1:0]                         row_valid_out,
    output logic                                                   busy_out,
    output logic                                                   done_out,
    output logic [BEAT_COUNT_WIDTH-1:0]                            beat_count_out
);

    localparam int DRAIN_CYCLES = SYSTOLIC_ARRAY_ROWS + SYSTOLIC_ARRAY_COLS - 1;
    localparam int DRAIN_CNT_W  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_CNT_W-1:0]      DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_CNT_W-1:0]      DRAIN_ONE  = DRAIN_CNT_W'(1);
    localparam logic [BEAT_COUNT_WIDTH-1:0] COUNT_ONE  = BEAT_COUNT_WIDTH'(1);
    localparam logic [BEAT_COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t                   state;
    logic [DRAIN_CNT_W-1:0]   drain_cnt;
    logic                     accept;

    assign act_ready_out = !rst_in && (state != DRAIN);
    assign accept        = act_valid_in && act_ready_out;

    // Frame control; done_out is set one cycle early so it lands in the final drain cycle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            drain_cnt      <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            beat_count_out <= '0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        beat_count_out <= COUNT_ONE;
                        busy_out       <= 1'b1;
                        drain_cnt      <= '0;
                        if (act_last_in) begin
                            state    <= DRAIN;
                            done_out <= (DRAIN_LAST == '0);
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (beat_count_out != COUNT_MAX) begin
                            beat_count_out <= beat_count_out + COUNT_ONE;
                        end
                        if (act_last_in) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                            done_out  <= (DRAIN_LAST == '0);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= IDLE;
                        busy_out  <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_ONE;
                        done_out  <= ((drain_cnt + DRAIN_ONE) == DRAIN_LAST);
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

    // Row r is an (r+1)-deep shift chain; non-accept cycles enter as zero data with valid low
    for (genvar r = 0; r < SYSTOLIC_ARRAY_ROWS; r++) begin : g_row
        logic [FIXED_POINT_WIDTH-1:0] data_q [0:r];
        logic [r:0]                   valid_q;

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                for (int s = 0; s <= r; s++) begin
                    data_q[s] <= '0;
                end
                valid_q <= '0;
            end else begin
                data_q[0]  <= accept ? act_in[r] : '0;
                valid_q[0] <= accept;
                for (int s = 1; s <= r; s++) begin
                    data_q[s]  <= data_q[s-1];
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        assign activations_out[r] = data_q[r];
        assign row_valid_out[r]   = valid_q[r];
    end

endmodule

// File: tb/tb_systolic_activation_skewer.sv
// Self-checking bench for systolic_activation_skewer: scoreboard of skewed row slots plus a
// timing model of ready/busy/done/beat count, driven by a frame table and hand-written sequences.
module tb_systolic_activation_skewer;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int W    = 16;
    localparam int BCW  = 5;
    localparam int D    = ROWS + COLS - 1;

    typedef logic [ROWS-1:0][W-1:0] vec_t;

    typedef struct {
        int          cyc;
        int          row;
        logic [W-1:0] data;
    } slot_t;

    typedef struct {
        int             beats;
        int             gap;
        logic [W-1:0]   base;
        logic [BCW-1:0] exp_count;
    } frame_vec_t;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic           act_valid_in;
    logic           act_last_in;
    vec_t           act_in;
    logic           act_ready_out;
    vec_t           activations_out;
    logic [ROWS-1:0] row_valid_out;
    logic           busy_out;
    logic           done_out;
    logic [BCW-1:0] beat_count_out;

    always #5 clk_in = ~clk_in;

    systolic_activation_skewer #(
        .SYSTOLIC_ARRAY_ROWS(ROWS),
        .SYSTOLIC_ARRAY_COLS(COLS),
        .FIXED_POINT_WIDTH  (W),
        .BEAT_COUNT_WIDTH   (BCW)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .act_valid_in   (act_valid_in),
        .act_last_in    (act_last_in),
        .act_in         (act_in),
        .act_ready_out  (act_ready_out),
        .activations_out(activations_out),
        .row_valid_out  (row_valid_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .beat_count_out (beat_count_out)
    );

    slot_t          slot_q[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    int             m_drain_end = -1;
    bit             m_streaming = 1'b0;
    logic [BCW-1:0] m_count = '0;
    int             last_accept_cyc = -1;
    int             done_seen_cyc = -1;
    int             row0_seen_cyc = -1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    function automatic vec_t uniformVec(input logic [W-1:0] val);
        vec_t v;
        for (int r = 0; r < ROWS; r++) v[r] = val;
        return v;
    endfunction

    function automatic vec_t rampVec(input logic [W-1:0] base);
        vec_t v;
        for (int r = 0; r < ROWS; r++) v[r] = base + W'(r);
        return v;
    endfunction

    function automatic vec_t randomVec();
        vec_t v;
        for (int r = 0; r < ROWS; r++) v[r] = W'($urandom);
        return v;
    endfunction

    // Compare this cycle's outputs against the scoreboard and timing model, then record any accept
    task automatic checkOutput();
        logic [ROWS-1:0] exp_v;
        vec_t            exp_d;
        bit              in_drain;
        bit              exp_ready;
        bit              acc;
        slot_t           keep[$];
        @(negedge clk_in);
        in_drain  = (m_drain_end >= 0) && (cyc <= m_drain_end);
        exp_ready = !rst_in && !in_drain;
        exp_v = '0;
        exp_d = '0;
        foreach (slot_q[i]) begin
            if (slot_q[i].cyc == cyc) begin
                exp_v[slot_q[i].row] = 1'b1;
                exp_d[slot_q[i].row] = slot_q[i].data;
            end
        end
        check("act_ready", 32'(act_ready_out), 32'(exp_ready));
        check("busy", 32'(busy_out), 32'(m_streaming || in_drain));
        check("done", 32'(done_out), 32'(in_drain && (cyc == m_drain_end)));
        check("beat_count", 32'(beat_count_out), 32'(m_count));
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("row%0d_valid", r), 32'(row_valid_out[r]), 32'(exp_v[r]));
            check($sformatf("row%0d_data", r), 32'(activations_out[r]), 32'(exp_d[r]));
        end
        if (done_out === 1'b1) done_seen_cyc = cyc;
        if (row_valid_out[0] === 1'b1) row0_seen_cyc = cyc;
        foreach (slot_q[i]) begin
            if (slot_q[i].cyc > cyc) keep.push_back(slot_q[i]);
        end
        slot_q = keep;
        acc = act_valid_in && exp_ready;
        if (rst_in) begin
            m_streaming = 1'b0;
            m_drain_end = -1;
            m_count     = '0;
            slot_q.delete();
        end else if (acc) begin
            last_accept_cyc = cyc;
            for (int r = 0; r < ROWS; r++) slot_q.push_back('{cyc + 1 + r, r, act_in[r]});
            if (!m_streaming) m_count = BCW'(1);
            else if (m_count != '1) m_count = m_count + BCW'(1);
            if (act_last_in) begin
                m_streaming = 1'b0;
                m_drain_end = cyc + D;
            end else begin
                m_streaming = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input bit l, input vec_t vec);
        act_valid_in = v;
        act_last_in  = l;
        act_in       = vec;
        checkOutput();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    // Hold valid high with junk through the drain window; the skewer must refuse all of it
    task automatic drainOut();
        for (int i = 0; i < D + 2; i++) begin
            if (cyc > m_drain_end) break;
            applyStimulus(1'b1, 1'b1, randomVec());
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        frame_vec_t frames[4];
        int         k;

        frames[0] = '{4, 0, 16'h0001, 5'd4};
        frames[1] = '{2, 2, 16'hA000, 5'd2};
        frames[2] = '{3, 1, 16'h0500, 5'd3};
        frames[3] = '{35, 0, 16'h1000, 5'd31};

        rst_in       = 1'b1;
        act_valid_in = 1'b1;
        act_last_in  = 1'b0;
        act_in       = randomVec();
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, randomVec());
        rst_in = 1'b0;
        applyStimulus(1'b0, 1'b1, randomVec());

        $display("[TB] single-beat frame");
        k = cyc;
        done_seen_cyc = -1;
        applyStimulus(1'b1, 1'b1, rampVec(16'h0100));
        drainOut();
        check("single_done_cycle", 32'(done_seen_cyc), 32'(k + 15));
        applyStimulus(1'b0, 1'b0, randomVec());
        check("single_beat_count", 32'(beat_count_out), 32'd1);

        $display("[TB] frame table");
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < frames[i].beats; b++) begin
                applyStimulus(1'b1, b == frames[i].beats - 1, uniformVec(frames[i].base + W'(b)));
                if (b != frames[i].beats - 1) begin
                    for (int g = 0; g < frames[i].gap; g++) applyStimulus(1'b0, 1'b1, randomVec());
                end
            end
            drainOut();
            applyStimulus(1'b0, 1'b0, randomVec());
            check($sformatf("frame%0d_beat_count", i), 32'(beat_count_out), 32'(frames[i].exp_count));
        end

        $display("[TB] reset mid-stream");
        for (int b = 0; b < 3; b++) applyStimulus(1'b1, 1'b0, rampVec(16'h2000 + W'(b * 16)));
        rst_in = 1'b1;
        applyStimulus(1'b1, 1'b0, randomVec());
        rst_in = 1'b0;
        applyStimulus(1'b0, 1'b0, randomVec());

        $display("[TB] reset mid-drain");
        k = cyc;
        applyStimulus(1'b1, 1'b1, rampVec(16'h3000));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, randomVec());
        done_seen_cyc = -1;
        rst_in = 1'b1;
        applyStimulus(1'b1, 1'b1, randomVec());
        rst_in = 1'b0;
        k = cyc;
        applyStimulus(1'b1, 1'b1, rampVec(16'h4000));
        drainOut();
        check("post_reset_done_cycle", 32'(done_seen_cyc), 32'(k + 15));
        applyStimulus(1'b0, 1'b0, randomVec());

        $display("[TB] back-to-back frames");
        applyStimulus(1'b1, 1'b0, uniformVec(16'h000A));
        applyStimulus(1'b1, 1'b1, uniformVec(16'h000B));
        k = cyc - 1;
        for (int i = 0; i < 30; i++) begin
            if (last_accept_cyc != k) break;
            applyStimulus(1'b1, 1'b1, uniformVec(16'h000C));
        end
        drainOut();
        check("b2b_row0_cycle", 32'(row0_seen_cyc), 32'(k + 17));
        applyStimulus(1'b0, 1'b0, randomVec());
        check("b2b_beat_count", 32'(beat_count_out), 32'd1);
        applyStimulus(1'b0, 1'b0, randomVec());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
